// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory behind the core's MEM-stage port.
// Stores merge byte/half/word lanes into the addressed word. Loads register
// the RAM word at the request edge and extract/extend the field in the
// following (WB) cycle. Bad requests raise a one-cycle misalign or
// access_fault pulse and never touch the RAM.
module dmem_ctrl #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [1:0]  mem_type,
   input  logic        mem_sign,
   input  logic        rmem,
   input  logic        wmem,
   output logic [31:0] mem_rdata,
   output logic        misalign,
   output logic        access_fault
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

   // Byte enables for a store of the given size at the given lane.
   function automatic logic [3:0] store_be(input logic [1:0] typ, input logic [1:0] lane);
      logic [3:0] be;
      case (typ)
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data so every candidate lane carries it.
   function automatic logic [31:0] store_data(input logic [1:0] typ, input logic [31:0] wd);
      logic [31:0] d;
      case (typ)
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   // Pull the addressed field out of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                                input logic [1:0] typ, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (typ)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         2'b10:   r = w;
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   logic [31:0]   ram_q [DEPTH];
   logic [31:0]   rd_word_q;
   logic          ld_vld_q, ld_vld_d;
   logic          ld_rej_q, ld_rej_d;
   logic [1:0]    lane_q, type_q;
   logic          sign_q;
   logic [31:0]   hold_q, hold_d;
   logic          misalign_q, misalign_d;
   logic          fault_q, fault_d;

   logic [31:0]   off_s;
   logic          in_range_s;
   logic [AW-1:0] idx_s;
   logic [1:0]    lane_s;
   logic          misal_raw_s;
   logic          st_ok_s;
   logic [3:0]    be_s;
   logic [31:0]   wd_s;

   assign off_s      = mem_addr - BASE_ADDR;
   assign in_range_s = ({1'b0, off_s} < LIMIT);
   assign idx_s      = off_s[AW+1:2];
   assign lane_s     = off_s[1:0];
   assign be_s       = store_be(mem_type, lane_s);
   assign wd_s       = store_data(mem_type, mem_wdata);

   // Request classification: alignment, fault priority, accepted load/store.
   always_comb begin
      misal_raw_s = 1'b0;
      fault_d     = 1'b0;
      misalign_d  = 1'b0;
      ld_vld_d    = 1'b0;
      ld_rej_d    = 1'b0;
      st_ok_s     = 1'b0;
      case (mem_type)
         2'b00:   misal_raw_s = 1'b0;
         2'b01:   misal_raw_s = lane_s[0];
         2'b10:   misal_raw_s = (lane_s != 2'b00);
         default: misal_raw_s = 1'b0;
      endcase
      if (rmem || wmem) begin
         fault_d    = !in_range_s || (mem_type == 2'b11) || (rmem && wmem);
         misalign_d = !fault_d && misal_raw_s;
         ld_vld_d   = rmem && !fault_d && !misal_raw_s;
         st_ok_s    = wmem && !fault_d && !misal_raw_s;
         ld_rej_d   = rmem && !ld_vld_d;
      end else begin
         fault_d    = 1'b0;
         misalign_d = 1'b0;
      end
   end

   // RAM array: masked byte writes and synchronous word read (not reset).
   always_ff @(posedge clk) begin
      if (rstn && st_ok_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               ram_q[idx_s][8*b +: 8] <= wd_s[8*b +: 8];
            end
         end
      end
      if (ld_vld_d) begin
         rd_word_q <= ram_q[idx_s];
      end
   end

   // Load-control, held-data and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ld_vld_q   <= 1'b0;
         ld_rej_q   <= 1'b0;
         lane_q     <= 2'b00;
         type_q     <= 2'b00;
         sign_q     <= 1'b0;
         hold_q     <= 32'h0000_0000;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         ld_vld_q   <= ld_vld_d;
         ld_rej_q   <= ld_rej_d;
         hold_q     <= hold_d;
         misalign_q <= misalign_d;
         fault_q    <= fault_d;
         if (ld_vld_d) begin
            lane_q <= lane_s;
            type_q <= mem_type;
            sign_q <= mem_sign;
         end
      end
   end

   // WB-cycle read data: fresh extraction, zero for a rejected load, else hold.
   always_comb begin
      hold_d = hold_q;
      if (ld_vld_q) begin
         hold_d = load_extract(rd_word_q, lane_q, type_q, sign_q);
      end else if (ld_rej_q) begin
         hold_d = 32'h0000_0000;
      end else begin
         hold_d = hold_q;
      end
   end

   assign mem_rdata    = hold_d;
   assign misalign     = misalign_q;
   assign access_fault = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with hand-computed expected values.
module tb_dmem_ctrl;

   logic        clk;
   logic        rstn;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_type;
   logic        mem_sign;
   logic        rmem;
   logic        wmem;
   logic [31:0] mem_rdata;
   logic        misalign;
   logic        access_fault;

   int n_checks;
   int n_errors;

   localparam logic [1:0] T_B = 2'b00;
   localparam logic [1:0] T_H = 2'b01;
   localparam logic [1:0] T_W = 2'b10;
   localparam logic [1:0] T_R = 2'b11;

   dmem_ctrl #(.DEPTH(4096), .BASE_ADDR(32'h0000_0000)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_type     (mem_type),
      .mem_sign     (mem_sign),
      .rmem         (rmem),
      .wmem         (wmem),
      .mem_rdata    (mem_rdata),
      .misalign     (misalign),
      .access_fault (access_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one request for a single cycle; returns #1 after the capturing edge.
   task automatic req(input logic rd, input logic wr, input logic [1:0] typ,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      rmem      = rd;
      wmem      = wr;
      mem_type  = typ;
      mem_sign  = sgn;
      mem_addr  = addr;
      mem_wdata = wd;
      @(posedge clk);
      #1;
      rmem = 1'b0;
      wmem = 1'b0;
   endtask

   task automatic idle();
      req(1'b0, 1'b0, T_W, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic flags(input string tag, input logic ma, input logic af);
      check_eq({tag, "_misalign"}, {31'd0, misalign}, {31'd0, ma});
      check_eq({tag, "_fault"}, {31'd0, access_fault}, {31'd0, af});
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rstn      = 1'b0;
      rmem      = 1'b0;
      wmem      = 1'b0;
      mem_type  = T_W;
      mem_sign  = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rdata", mem_rdata, 32'h0);
      flags("rst", 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

      // Word store then back-to-back load
      req(1'b0, 1'b1, T_W, 1'b0, 32'h10, 32'hDEAD_BEEF);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h10, 32'h0);
      check_eq("lw_10", mem_rdata, 32'hDEAD_BEEF);
      flags("lw_10", 1'b0, 1'b0);
      idle();
      check_eq("hold_10", mem_rdata, 32'hDEAD_BEEF);

      // Byte lanes
      req(1'b0, 1'b1, T_W, 1'b0, 32'h20, 32'h1122_3344);
      req(1'b0, 1'b1, T_B, 1'b0, 32'h22, 32'h0000_00AA);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h20, 32'h0);
      check_eq("lw_20", mem_rdata, 32'h11AA_3344);
      req(1'b1, 1'b0, T_B, 1'b1, 32'h22, 32'h0);
      check_eq("lb_22", mem_rdata, 32'hFFFF_FFAA);
      req(1'b1, 1'b0, T_B, 1'b0, 32'h22, 32'h0);
      check_eq("lbu_22", mem_rdata, 32'h0000_00AA);
      req(1'b1, 1'b0, T_B, 1'b1, 32'h23, 32'h0);
      check_eq("lb_23", mem_rdata, 32'h0000_0011);
      req(1'b1, 1'b0, T_H, 1'b1, 32'h20, 32'h0);
      check_eq("lh_20", mem_rdata, 32'h0000_3344);

      // Halfwords
      req(1'b0, 1'b1, T_W, 1'b0, 32'h30, 32'hCAFE_1234);
      req(1'b0, 1'b1, T_H, 1'b0, 32'h32, 32'h0000_8001);
      req(1'b1, 1'b0, T_H, 1'b1, 32'h32, 32'h0);
      check_eq("lh_32", mem_rdata, 32'hFFFF_8001);
      req(1'b1, 1'b0, T_H, 1'b0, 32'h32, 32'h0);
      check_eq("lhu_32", mem_rdata, 32'h0000_8001);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h30, 32'h0);
      check_eq("lw_30", mem_rdata, 32'h8001_1234);

      // Misalignment
      req(1'b0, 1'b1, T_W, 1'b0, 32'h40, 32'h5566_7788);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h40, 32'h0);
      check_eq("lw_40", mem_rdata, 32'h5566_7788);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h41, 32'h0);
      check_eq("lw_41_rdata", mem_rdata, 32'h0);
      flags("lw_41", 1'b1, 1'b0);
      idle();
      flags("lw_41_after", 1'b0, 1'b0);
      req(1'b0, 1'b1, T_H, 1'b0, 32'h43, 32'h0000_BBBB);
      flags("sh_43", 1'b1, 1'b0);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h40, 32'h0);
      check_eq("lw_40_kept", mem_rdata, 32'h5566_7788);
      flags("lw_40_kept", 1'b0, 1'b0);

      // Faults
      req(1'b1, 1'b0, T_W, 1'b0, 32'h0000_4000, 32'h0);
      check_eq("lw_oor_rdata", mem_rdata, 32'h0);
      flags("lw_oor", 1'b0, 1'b1);
      idle();
      flags("lw_oor_after", 1'b0, 1'b0);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h0000_4001, 32'h0);
      check_eq("lw_oor_mis_rdata", mem_rdata, 32'h0);
      flags("lw_oor_mis", 1'b0, 1'b1);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h10, 32'h0);
      req(1'b1, 1'b0, T_R, 1'b0, 32'h10, 32'h0);
      check_eq("rsv_rdata", mem_rdata, 32'h0);
      flags("rsv", 1'b0, 1'b1);
      req(1'b1, 1'b1, T_W, 1'b0, 32'h10, 32'h1234_5678);
      flags("rw_both", 1'b0, 1'b1);
      req(1'b1, 1'b0, T_W, 1'b0, 32'h10, 32'h0);
      check_eq("rw_both_nowrite", mem_rdata, 32'hDEAD_BEEF);
      req(1'b0, 1'b1, T_W, 1'b0, 32'h4000, 32'h1111_1111);
      flags("sw_oor", 1'b0, 1'b1);

      // Reset with a load in flight; RAM retained afterwards
      @(negedge clk);
      rmem     = 1'b1;
      wmem     = 1'b0;
      mem_type = T_W;
      mem_addr = 32'h10;
      rstn     = 1'b0;
      @(posedge clk);
      #1;
      rmem = 1'b0;
      check_eq("rst_ld_rdata", mem_rdata, 32'h0);
      flags("rst_ld", 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      req(1'b1, 1'b0, T_W, 1'b0, 32'h10, 32'h0);
      check_eq("lw_10_post_rst", mem_rdata, 32'hDEAD_BEEF);
      flags("lw_10_post_rst", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
